// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s serializer.
// Optional feature macro: P2S_PARITY_EN (adds the even-parity bit and the PARITY state).
package p2s_pkg;

  localparam int P2S_DEFAULT_WIDTH = 10;

`ifdef P2S_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } p2s_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } p2s_state_e;
`endif

endpackage

// File: rtl/p2s.sv
// p2s: parallel-to-serial framer with registered outputs and back-to-back frames.
// Optional feature macro: P2S_PARITY_EN (one even-parity bit appended after the data bits).
module p2s
  import p2s_pkg::*;
#(
  parameter int WIDTH     = P2S_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_sync,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  p2s_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] din_rest;
  logic [WIDTH-1:0] shreg_adv;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
`ifdef P2S_PARITY_EN
  logic             par;
`endif

  // Bit selection for the configured order; the first bit goes straight to dout
  // at load, so the shift register keeps only the remaining bits.
  always_comb begin
    accept = din_valid & din_ready;
    if (MSB_FIRST) begin
      first_bit = din[WIDTH-1];
      din_rest  = din << 1;
      next_bit  = shreg[WIDTH-1];
      shreg_adv = shreg << 1;
    end else begin
      first_bit = din[0];
      din_rest  = din >> 1;
      next_bit  = shreg[0];
      shreg_adv = shreg >> 1;
    end
  end

  // Frame FSM; din_ready is registered as a look-ahead of "next cycle is IDLE or final bit".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      dout      <= 1'b0;
      dout_sync <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b0;
`ifdef P2S_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      state     <= SHIFT;
      shreg     <= din_rest;
      cnt       <= '0;
      dout      <= first_bit;
      dout_sync <= 1'b1;
      busy      <= 1'b1;
`ifdef P2S_PARITY_EN
      par       <= ^din;
      din_ready <= 1'b0;
`else
      din_ready <= (LAST == '0);
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef P2S_PARITY_EN
            state     <= PARITY;
            dout      <= par;
            dout_sync <= 1'b0;
            din_ready <= 1'b1;
`else
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            dout      <= 1'b0;
            dout_sync <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
`endif
          end else begin
            shreg     <= shreg_adv;
            dout      <= next_bit;
            dout_sync <= 1'b0;
            cnt       <= cnt + 1'b1;
`ifdef P2S_PARITY_EN
            din_ready <= 1'b0;
`else
            din_ready <= ((cnt + 1'b1) == LAST);
`endif
          end
        end
        default: begin
          state     <= IDLE;
          shreg     <= '0;
          cnt       <= '0;
          dout      <= 1'b0;
          dout_sync <= 1'b0;
          busy      <= 1'b0;
          din_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
